// File: rtl/xup_gate_pkg.sv
`default_nettype none
// ============================================================================
// Module   : xup_gate_pkg
// Purpose  : Shared definitions for the pipelined wide reduction gate.
//            Provides the function-select codes, the tree base operation
//            type, the identity (padding) bit per mode, the base-op and
//            output-invert decode, and a ceil(log2) helper.
// Revision : 1.0 - initial release
// ============================================================================
package xup_gate_pkg;

    // Function-select codes carried on in_mode; 6 and 7 are reserved.
    localparam logic [2:0] MODE_AND  = 3'd0;
    localparam logic [2:0] MODE_NAND = 3'd1;
    localparam logic [2:0] MODE_OR   = 3'd2;
    localparam logic [2:0] MODE_NOR  = 3'd3;
    localparam logic [2:0] MODE_XOR  = 3'd4;
    localparam logic [2:0] MODE_XNOR = 3'd5;

    // Operation applied at every tree level; OP_ZERO covers reserved modes.
    typedef enum logic [1:0] {
        OP_AND  = 2'd0,
        OP_OR   = 2'd1,
        OP_XOR  = 2'd2,
        OP_ZERO = 2'd3
    } base_op_e;

    // ceil(log2(n)); returns 0 for n <= 1.
    function automatic int unsigned f_clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Padding leaves must not disturb the result: 1 for the AND family,
    // 0 for the OR and XOR families.
    function automatic logic f_identity(input logic [2:0] mode);
        return (mode == MODE_AND) || (mode == MODE_NAND);
    endfunction

    // Tree operation used by every level for a given mode.
    function automatic base_op_e f_base_op(input logic [2:0] mode);
        base_op_e op;
        case (mode)
            MODE_AND, MODE_NAND: op = OP_AND;
            MODE_OR,  MODE_NOR:  op = OP_OR;
            MODE_XOR, MODE_XNOR: op = OP_XOR;
            default:             op = OP_ZERO;
        endcase
        return op;
    endfunction

    // Output inversion for the complemented modes.
    function automatic logic f_invert(input logic [2:0] mode);
        return (mode == MODE_NAND) || (mode == MODE_NOR) || (mode == MODE_XNOR);
    endfunction

endpackage
`default_nettype wire

// File: rtl/xup_gate_reduce_stage.sv
`default_nettype none
// ============================================================================
// Module   : xup_gate_reduce_stage
// Purpose  : One registered level of the reduction tree. Combines adjacent
//            pairs of its IN_W input bits with the mode's base operation and
//            registers the IN_W/2 results together with valid and mode.
//            The stage loads whenever it is empty or its successor advances.
// Ports    : clk, rst        - clock, synchronous active-high reset
//            i_valid/i_mode/i_data - upstream transaction
//            i_next_adv      - successor (or downstream) takes data this cycle
//            o_adv           - this stage loads new content this cycle
//            o_valid/o_mode/o_data - registered stage content
// Revision : 1.0 - initial release
// ============================================================================
module xup_gate_reduce_stage
    import xup_gate_pkg::*;
#(
    parameter int IN_W = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_valid,
    input  logic [2:0]          i_mode,
    input  logic [IN_W-1:0]     i_data,
    input  logic                i_next_adv,
    output logic                o_adv,
    output logic                o_valid,
    output logic [2:0]          o_mode,
    output logic [IN_W/2-1:0]   o_data
);

    localparam int c_OUT_W = IN_W / 2;

    logic                r_valid;
    logic [2:0]          r_mode;
    logic [c_OUT_W-1:0]  r_data;
    logic [c_OUT_W-1:0]  w_level;
    base_op_e            w_op;

    assign w_op = f_base_op(i_mode);

    always_comb begin
        w_level = '0;
        for (int i = 0; i < c_OUT_W; i++) begin
            case (w_op)
                OP_AND:  w_level[i] = i_data[2*i] & i_data[2*i+1];
                OP_OR:   w_level[i] = i_data[2*i] | i_data[2*i+1];
                OP_XOR:  w_level[i] = i_data[2*i] ^ i_data[2*i+1];
                default: w_level[i] = 1'b0;
            endcase
        end
    end

    // A full stage can only move when the next one makes room.
    assign o_adv = ~r_valid | i_next_adv;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_mode  <= '0;
            r_data  <= '0;
        end else if (o_adv) begin
            r_valid <= i_valid;
            r_mode  <= i_mode;
            r_data  <= w_level;
        end
    end

    assign o_valid = r_valid;
    assign o_mode  = r_mode;
    assign o_data  = r_data;

endmodule
`default_nettype wire

// File: rtl/xup_gate_reduce_pipe.sv
`default_nettype none
// ============================================================================
// Module   : xup_gate_reduce_pipe
// Purpose  : Pipelined WIDTH-input reduction gate with per-transaction
//            function select (AND/NAND/OR/NOR/XOR/XNOR, reserved -> 0).
//            Input is padded to 2^LEVELS leaves with the mode's identity
//            bit and reduced by LEVELS registered tree stages behind a
//            valid/ready handshake; one transaction per cycle.
// Ports    : clk, reset (sync, active-high)
//            in_valid/in_ready/in_data[WIDTH]/in_mode[3]  - input channel
//            out_valid/out_ready/y                        - result channel
//            ones_cnt[16] - count of y=1 output handshakes (XUP_GATE_CNT_EN)
// Options  : define XUP_GATE_CNT_EN to add the ones_cnt port and counter.
// Revision : 1.0 - initial release
// ============================================================================
module xup_gate_reduce_pipe
    import xup_gate_pkg::*;
#(
    parameter int WIDTH = 6,
    parameter int DELAY = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WIDTH-1:0]    in_data,
    input  logic [2:0]          in_mode,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                y
`ifdef XUP_GATE_CNT_EN
    ,
    output logic [15:0]         ones_cnt
`endif
);

    localparam int c_LOG2   = int'(f_clog2(WIDTH));
    localparam int LEVELS   = (c_LOG2 < 1) ? 1 : c_LOG2;
    localparam int c_LEAVES = 1 << LEVELS;
    // All tree levels packed back to back: level k holds c_LEAVES>>k bits
    // starting at 2*c_LEAVES - 2*(c_LEAVES>>k); the root bit is the MSB.
    localparam int c_BUS_W  = 2 * c_LEAVES - 1;

    // DELAY only shapes timing of the behavioural library model and has no
    // hardware counterpart; negative values are meaningless.
    if (DELAY < 0) begin : g_delay_range
    end

    logic [c_BUS_W-1:0]  w_bus;
    logic [c_LEAVES-1:0] w_leaves;
    logic                w_pad;
    logic [LEVELS:0]     w_valid;
    logic [LEVELS:0]     w_adv;
    logic [2:0]          w_mode [0:LEVELS];
    logic [2:0]          w_out_mode;
    logic                w_root;

    assign w_pad = f_identity(in_mode);

    always_comb begin
        w_leaves                = {c_LEAVES{w_pad}};
        w_leaves[WIDTH-1:0]     = in_data;
    end

    assign w_bus[c_LEAVES-1:0] = w_leaves;
    assign w_valid[0]          = in_valid;
    assign w_mode[0]           = in_mode;
    assign w_adv[LEVELS]       = out_ready;

    for (genvar k = 0; k < LEVELS; k++) begin : g_level
        localparam int c_IN_W    = c_LEAVES >> k;
        localparam int c_OFF_IN  = 2 * c_LEAVES - 2 * c_IN_W;
        localparam int c_OFF_OUT = c_OFF_IN + c_IN_W;

        xup_gate_reduce_stage #(
            .IN_W (c_IN_W)
        ) u_stage (
            .clk        (clk),
            .rst        (reset),
            .i_valid    (w_valid[k]),
            .i_mode     (w_mode[k]),
            .i_data     (w_bus[c_OFF_IN +: c_IN_W]),
            .i_next_adv (w_adv[k+1]),
            .o_adv      (w_adv[k]),
            .o_valid    (w_valid[k+1]),
            .o_mode     (w_mode[k+1]),
            .o_data     (w_bus[c_OFF_OUT +: c_IN_W/2])
        );
    end

    // Reset holds off new input so nothing can slip in as the pipe clears.
    assign in_ready  = ~reset & w_adv[0];
    assign out_valid = w_valid[LEVELS];

    // Complement and reserved-mode forcing happen only at the root, using
    // the mode that travelled with this transaction; all inputs here are
    // registers, so y holds steady while the last stage is stalled.
    assign w_out_mode = w_mode[LEVELS];
    assign w_root     = w_bus[c_BUS_W-1];
    assign y          = (f_base_op(w_out_mode) == OP_ZERO) ? 1'b0
                                                           : (w_root ^ f_invert(w_out_mode));

`ifdef XUP_GATE_CNT_EN
    logic [15:0] r_ones_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ones_cnt <= '0;
        end else if (out_valid && out_ready && y) begin
            r_ones_cnt <= r_ones_cnt + 16'd1;
        end
    end

    assign ones_cnt = r_ones_cnt;
`endif

endmodule
`default_nettype wire
